// File: rtl/mem_handshake_ctrl_pkg.sv
// mem_pkg: size encodings, FSM states and memory geometry shared by mem_handshake_ctrl.
package mem_pkg;
   localparam int MEM_BYTES = 512;
   localparam int MEM_AW = $clog2(MEM_BYTES);
   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;
   function automatic logic [2:0] nbytes(input logic [1:0] sz);
      return (sz == SZ_BYTE) ? 3'd1 : (sz == SZ_HALF) ? 3'd2 : 3'd4;
   endfunction
   // the reserved size code behaves as a word
   function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] a);
      return (sz == SZ_HALF && a[0]) || (sz >= SZ_WORD && a != 2'b00);
   endfunction
endpackage

// File: rtl/mem_handshake_ctrl_byte_pack.sv
// mem_byte_pack: big-endian write byte select and read extension by access size.
// MEM_HANDSHAKE_SIGN_EXT_EN selects sign extension of byte/halfword reads (zero extension otherwise).
module mem_byte_pack
   import mem_pkg::*;
(
   input  logic [1:0]  i_size,
   input  logic [2:0]  i_cnt,
   input  logic [31:0] i_mdr,
   input  logic [31:0] i_rd,
   output logic [7:0]  o_wbyte,
   output logic [31:0] o_rd_ext
);
   logic [1:0] w_sh;
   assign w_sh = 2'(nbytes(i_size) - 3'd1 - i_cnt);
   assign o_wbyte = i_mdr[{w_sh, 3'b000} +: 8];
`ifdef MEM_HANDSHAKE_SIGN_EXT_EN
   assign o_rd_ext = (i_size == SZ_BYTE) ? {{24{i_rd[7]}}, i_rd[7:0]} :
                     (i_size == SZ_HALF) ? {{16{i_rd[15]}}, i_rd[15:0]} : i_rd;
`else
   assign o_rd_ext = (i_size == SZ_BYTE) ? {24'd0, i_rd[7:0]} :
                     (i_size == SZ_HALF) ? {16'd0, i_rd[15:0]} : i_rd;
`endif
endmodule

// File: rtl/mem_handshake_ctrl.sv
// mem_handshake_ctrl: MOV/MOC byte-sequencing controller for a 512-byte big-endian RAM.
// Build option MEM_HANDSHAKE_SIGN_EXT_EN sign-extends byte/halfword reads.
module mem_handshake_ctrl
   import mem_pkg::*;
#(
   parameter int ADDR_WIDTH = MEM_AW,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  mov,
   input  logic                  rw,
   input  logic [1:0]            size,
   input  logic                  mar_ld,
   input  logic [DATA_WIDTH-1:0] mar_in,
   input  logic                  mdr_ld,
   input  logic [DATA_WIDTH-1:0] mdr_in,
   output logic                  moc,
   output logic [DATA_WIDTH-1:0] mdr_out,
   output logic                  align_err,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [7:0]            ram_wdata,
   output logic                  ram_we,
   input  logic [7:0]            ram_rdata
);
   state_t r_state, w_next;
   logic [ADDR_WIDTH-1:0] r_mar;
   logic [DATA_WIDTH-1:0] r_mdr;
   logic [23:0] r_asm;
   logic [2:0] r_cnt;
   logic r_rw;
   logic [1:0] r_size;
   logic r_align;
   logic [2:0] w_n;
   logic w_last;
   logic w_mis;
   logic [31:0] w_asm;
   logic [31:0] w_rd_ext;
   logic [7:0] w_wbyte;
   logic w_unused_mar;
   assign w_unused_mar = ^mar_in[DATA_WIDTH-1:ADDR_WIDTH];
   assign w_n = nbytes(r_size);
   // reads need one extra cycle to drain the synchronous RAM latency
   assign w_last = (r_cnt == (r_rw ? w_n : w_n - 3'd1));
   assign w_mis = misaligned(size, r_mar[1:0]);
   assign w_asm = {r_asm, ram_rdata};
   mem_byte_pack u_pack (
      .i_size(r_size),
      .i_cnt(r_cnt),
      .i_mdr(r_mdr),
      .i_rd(w_asm),
      .o_wbyte(w_wbyte),
      .o_rd_ext(w_rd_ext)
   );
   always_comb begin
      w_next = (r_state == IDLE) ? (mov ? (w_mis ? DONE : XFER) : IDLE) :
               (r_state == XFER) ? (w_last ? DONE : XFER) :
               (mov ? DONE : IDLE);
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         r_mar <= '0;
         r_mdr <= '0;
         r_asm <= '0;
         r_cnt <= '0;
         r_rw <= 1'b0;
         r_size <= SZ_BYTE;
         r_align <= 1'b0;
      end else begin
         r_state <= w_next;
         if (r_state == IDLE) begin
            if (mar_ld) r_mar <= mar_in[ADDR_WIDTH-1:0];
            if (mdr_ld) r_mdr <= mdr_in;
            if (mov) begin
               r_rw <= rw;
               r_size <= size;
               r_cnt <= '0;
               r_asm <= '0;
               r_align <= w_mis;
            end
         end else if (r_state == XFER) begin
            r_cnt <= r_cnt + 3'd1;
            if (r_rw && r_cnt != 3'd0) r_asm <= w_asm[23:0];
            if (r_rw && w_last) r_mdr <= w_rd_ext;
         end else if (!mov) begin
            r_align <= 1'b0;
         end
      end
   end
   assign moc = (r_state == DONE);
   assign align_err = r_align;
   assign mdr_out = r_mdr;
   assign ram_we = (r_state == XFER) && !r_rw;
   assign ram_addr = r_mar + ADDR_WIDTH'(r_cnt);
   assign ram_wdata = ram_we ? w_wbyte : 8'd0;
endmodule

// File: tb/tb_mem_handshake_ctrl.sv
// tb_mem_handshake_ctrl: directed bench with a transaction-level model, RAM model and per-cycle compare.
// Honours MEM_HANDSHAKE_SIGN_EXT_EN for the expected read extension.
module tb_mem_handshake_ctrl;
   import mem_pkg::*;
   logic clk = 1'b0, rst = 1'b0, mov = 1'b0, rw = 1'b0, mar_ld = 1'b0, mdr_ld = 1'b0;
   logic [1:0] size = 2'b00;
   logic [31:0] mar_in = 32'd0, mdr_in = 32'd0;
   logic moc, align_err, ram_we;
   logic [31:0] mdr_out;
   logic [8:0] ram_addr;
   logic [7:0] ram_wdata, ram_rdata;
   int n_cmp = 0, n_bad = 0;
   logic [7:0] ram [512];
   logic [7:0] ref_mem [512];
   int m_ph = 0, m_left = 0, m_k = 0, m_n = 1;
   logic m_rw = 1'b0, m_align = 1'b0;
   logic [8:0] m_mar = 9'd0;
   logic [31:0] m_mdr = 32'd0;
`ifdef MEM_HANDSHAKE_SIGN_EXT_EN
   localparam logic [31:0] EXP_B80 = 32'hFFFFFF80;
   localparam logic [31:0] EXP_H8001 = 32'hFFFF8001;
`else
   localparam logic [31:0] EXP_B80 = 32'h00000080;
   localparam logic [31:0] EXP_H8001 = 32'h00008001;
`endif

   mem_handshake_ctrl dut (
      .clk(clk), .reset(rst), .mov(mov), .rw(rw), .size(size),
      .mar_ld(mar_ld), .mar_in(mar_in), .mdr_ld(mdr_ld), .mdr_in(mdr_in),
      .moc(moc), .mdr_out(mdr_out), .align_err(align_err),
      .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata)
   );

   always #5 clk = ~clk;

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
      end
   endfunction

   function automatic logic [31:0] ext(input logic [31:0] v, input int n);
`ifdef MEM_HANDSHAKE_SIGN_EXT_EN
      if (n == 1) return {{24{v[7]}}, v[7:0]};
      if (n == 2) return {{16{v[15]}}, v[15:0]};
`endif
      return v;
   endfunction

   // big-endian: byte k of an N-byte write is the k-th most significant of the low N bytes
   function automatic logic [7:0] wbyte(input int k);
      return 8'(m_mdr >> (8 * (m_n - 1 - k)));
   endfunction

   function automatic int maddr(input int k);
      return (32'(m_mar) + k) % MEM_BYTES;
   endfunction

   initial begin
      for (int i = 0; i < 512; i++) ram[i] = 8'h00;
      ram[9'h21] = 8'h80;
      ram[9'h22] = 8'h80;
      ram[9'h23] = 8'h01;
      forever begin
         @(posedge clk);
         if (ram_we) ram[ram_addr] <= ram_wdata;
         ram_rdata <= ram[ram_addr];
      end
   end

   // transaction model: phase 0 idle, 1 busy for a fixed number of edges, 2 completed
   initial begin
      logic [31:0] v;
      for (int i = 0; i < 512; i++) ref_mem[i] = 8'h00;
      ref_mem[9'h21] = 8'h80;
      ref_mem[9'h22] = 8'h80;
      ref_mem[9'h23] = 8'h01;
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            m_ph = 0; m_mar = 9'd0; m_mdr = 32'd0; m_align = 1'b0; m_k = 0;
         end else if (m_ph == 0) begin
            if (mov) begin
               m_n = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
               m_rw = rw;
               m_k = 0;
               if ((m_n == 2 && m_mar[0]) || (m_n == 4 && m_mar[1:0] != 2'b00)) begin
                  m_ph = 2; m_align = 1'b1;
               end else begin
                  m_ph = 1; m_left = rw ? m_n + 1 : m_n;
               end
            end
            if (mar_ld) m_mar = mar_in[8:0];
            if (mdr_ld) m_mdr = mdr_in;
         end else if (m_ph == 1) begin
            if (!m_rw) begin
               ref_mem[maddr(m_k)] = wbyte(m_k);
               m_k++;
            end
            m_left--;
            if (m_left == 0) begin
               m_ph = 2;
               if (m_rw) begin
                  v = 32'd0;
                  for (int i = 0; i < m_n; i++) v = (v << 8) | 32'(ref_mem[maddr(i)]);
                  m_mdr = ext(v, m_n);
               end
            end
         end else if (!mov) begin
            m_ph = 0; m_align = 1'b0;
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         chk("moc", 32'(moc), 32'(m_ph == 2));
         chk("align_err", 32'(align_err), 32'(m_align));
         chk("mdr_out", mdr_out, m_mdr);
         chk("ram_we", 32'(ram_we), 32'(m_ph == 1 && !m_rw));
         if (m_ph == 1 && !m_rw) begin
            chk("ram_addr", 32'(ram_addr), 32'(maddr(m_k)));
            chk("ram_wdata", 32'(ram_wdata), 32'(wbyte(m_k)));
         end
      end
   end

   task automatic ld(input logic lm, input logic [31:0] a, input logic lmd, input logic [31:0] d);
      @(negedge clk);
      mar_ld = lm; mar_in = a; mdr_ld = lmd; mdr_in = d;
      @(negedge clk);
      mar_ld = 1'b0; mdr_ld = 1'b0;
   endtask

   // lat counts edges after the mov sample edge until moc is seen
   task automatic go(input logic r, input logic [1:0] sz, input int extra, input logic early,
                     output int lat, output logic al);
      @(negedge clk);
      mov = 1'b1; rw = r; size = sz;
      @(posedge clk); #1;
      if (early) mov = 1'b0;
      lat = 0;
      while (!moc && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      if (!moc) chk("moc_timeout", 32'(moc), 32'd1);
      al = align_err;
      repeat (extra) begin
         @(posedge clk); #1;
         chk("moc_hold", 32'(moc), 32'd1);
      end
      mov = 1'b0;
      @(posedge clk); #1;
      chk("moc_release", 32'(moc), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, diff;
      logic al;
      #2 rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_moc", 32'(moc), 32'd0);
      chk("rst_mdr", mdr_out, 32'd0);
      chk("rst_we", 32'(ram_we), 32'd0);
      chk("rst_addr", 32'(ram_addr), 32'd0);
      chk("rst_wdata", 32'(ram_wdata), 32'd0);
      chk("rst_align", 32'(align_err), 32'd0);
      rst = 1'b0;
      ld(1'b1, 32'h10, 1'b1, 32'hDEADBEEF);
      go(1'b0, SZ_WORD, 0, 1'b0, lat, al);
      chk("wr_word_lat", 32'(lat), 32'd4);
      chk("wr_word_ram", {ram[9'h10], ram[9'h11], ram[9'h12], ram[9'h13]}, 32'hDEADBEEF);
      ld(1'b0, 32'd0, 1'b1, 32'd0);
      go(1'b1, SZ_WORD, 0, 1'b0, lat, al);
      chk("rd_word_lat", 32'(lat), 32'd5);
      chk("rd_word", mdr_out, 32'hDEADBEEF);
      ld(1'b1, 32'h21, 1'b0, 32'd0);
      go(1'b1, SZ_BYTE, 0, 1'b0, lat, al);
      chk("rd_byte_lat", 32'(lat), 32'd2);
      chk("rd_byte", mdr_out, EXP_B80);
      ld(1'b1, 32'h22, 1'b0, 32'd0);
      go(1'b1, SZ_HALF, 0, 1'b0, lat, al);
      chk("rd_half_lat", 32'(lat), 32'd3);
      chk("rd_half", mdr_out, EXP_H8001);
      ld(1'b1, 32'h06, 1'b1, 32'h12345678);
      go(1'b0, SZ_WORD, 0, 1'b0, lat, al);
      chk("misalign_lat", 32'(lat), 32'd0);
      chk("misalign_err", 32'(al), 32'd1);
      chk("misalign_ram", {ram[9'h06], ram[9'h07], ram[9'h08], ram[9'h09]}, 32'd0);
      chk("misalign_mdr", mdr_out, 32'h12345678);
      ld(1'b1, 32'h1FC, 1'b1, 32'hCAFEF00D);
      go(1'b0, SZ_WORD, 0, 1'b0, lat, al);
      chk("wrap_word_ram", {ram[9'h1FC], ram[9'h1FD], ram[9'h1FE], ram[9'h1FF]}, 32'hCAFEF00D);
      ld(1'b1, 32'h0000_0201, 1'b1, 32'h000000A5);
      go(1'b0, SZ_BYTE, 0, 1'b0, lat, al);
      chk("wr_byte_lat", 32'(lat), 32'd1);
      chk("wrap_byte_ram", {ram[9'h000], ram[9'h001], ram[9'h002]}, 32'h0000A500);
      ld(1'b1, 32'h30, 1'b1, 32'h01020304);
      go(1'b0, SZ_WORD, 3, 1'b0, lat, al);
      chk("hold_ram", {ram[9'h30], ram[9'h31], ram[9'h32], ram[9'h33]}, 32'h01020304);
      ld(1'b1, 32'h34, 1'b1, 32'h0000BEEF);
      go(1'b0, SZ_HALF, 0, 1'b1, lat, al);
      chk("early_lat", 32'(lat), 32'd2);
      chk("early_ram", {ram[9'h34], ram[9'h35]}, 32'h0000BEEF);
      ld(1'b1, 32'h10, 1'b1, 32'd0);
      fork
         go(1'b1, SZ_WORD, 0, 1'b0, lat, al);
         begin
            @(negedge clk);
            @(posedge clk); #2;
            mar_ld = 1'b1; mar_in = 32'h100;
            @(posedge clk); #2;
            mar_ld = 1'b0;
         end
      join
      chk("xfer_marld_rd", mdr_out, 32'hDEADBEEF);
      ld(1'b0, 32'd0, 1'b1, 32'd0);
      go(1'b1, SZ_WORD, 0, 1'b0, lat, al);
      chk("mar_kept", mdr_out, 32'hDEADBEEF);
      ld(1'b1, 32'h40, 1'b1, 32'h11223344);
      @(negedge clk);
      mov = 1'b1; rw = 1'b0; size = SZ_WORD;
      @(posedge clk);
      @(posedge clk); #3;
      rst = 1'b1;
      #1;
      chk("arst_moc", 32'(moc), 32'd0);
      chk("arst_we", 32'(ram_we), 32'd0);
      chk("arst_mdr", mdr_out, 32'd0);
      chk("arst_addr", 32'(ram_addr), 32'd0);
      mov = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      chk("arst_ram", {ram[9'h40], ram[9'h41], ram[9'h42], ram[9'h43]}, 32'h11000000);
      go(1'b1, SZ_HALF, 0, 1'b0, lat, al);
      chk("arst_mar_zero", mdr_out, 32'h000000A5);
      diff = 0;
      for (int i = 0; i < 512; i++) if (ram[i] !== ref_mem[i]) diff++;
      chk("ram_image", 32'(diff), 32'd0);
      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/mem_handshake_ctrl.md
Name: mem_handshake_ctrl

Overview:
- Byte-sequencing memory controller between the CPU control unit and the 512-byte, byte-organised, big-endian data memory.
- Holds the MAR and MDR registers.
- Accepts one access per MOV/MOC handshake and performs 1, 2 or 4 single-byte RAM cycles.
- Reads are assembled into the MDR; writes are split out from the MDR, most-significant byte at the lowest address.

Parameters:
- ADDR_WIDTH, 9: byte-address bits driven to the RAM (512 bytes).
- DATA_WIDTH, 32: MAR/MDR width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- mov  in  1  memory operation valid; held high until moc is seen.
- rw  in  1  1 = read, 0 = write; sampled with mov.
- size  in  2  00 = byte, 01 = halfword, 10 = word, 11 = reserved (treated as word).
- mar_ld  in  1  load mar_in into MAR (IDLE only).
- mar_in  in  32  address source.
- mdr_ld  in  1  load mdr_in into MDR (IDLE only).
- mdr_in  in  32  write-data source.
- moc  out  1  memory operation complete.
- mdr_out  out  32  MDR contents.
- align_err  out  1  access aborted, misaligned; valid while moc = 1.
- ram_addr  out  ADDR_WIDTH  byte address to the RAM.
- ram_wdata  out  8  byte to write.
- ram_we  out  1  RAM write strobe; write commits at the next rising edge.
- ram_rdata  in  8  RAM read byte, one-cycle synchronous latency.

Behaviour:
- Reset (asynchronous):
  - State IDLE; MAR = 0, MDR = 0, byte counter = 0.
  - moc = 0, align_err = 0, ram_we = 0, ram_addr = 0, ram_wdata = 0.
  - Reset mid-transfer aborts the transfer; bytes already written stay in RAM.
- States: IDLE, XFER, DONE.
- IDLE:
  - mar_ld and mdr_ld act here only; they are ignored in XFER and DONE.
  - If mdr_ld and a read completion coincide, the read result wins.
  - At the edge where mov = 1 (edge E0): latch rw and size, N = 1/2/4, counter = 0.
  - Misalignment: half with MAR[0] = 1, or word with MAR[1:0] != 0. On misalignment go to DONE with align_err = 1; no RAM access occurs and the MDR is unchanged.
  - Otherwise go to XFER.
- XFER, write:
  - ram_addr = MAR[ADDR_WIDTH-1:0] + counter, wrapping modulo 512.
  - ram_we = 1 in each of N cycles.
  - ram_wdata = byte (4-N+counter) of MDR, counting byte 0 as MSB, i.e. the big-endian split of the low N bytes.
  - Writes commit at E1..EN; go to DONE at EN.
- XFER, read:
  - Addresses are issued on E0..E(N-1) cycles.
  - The byte issued in cycle k is captured at E(k+2) by shifting it into a read assembly register, MSB first.
  - The XFER state lasts N+1 cycles; at E(N+1) the MDR is loaded with the result and the state goes to DONE.
  - Byte and halfword results are zero-extended unless SIGN_EXT_EN is defined.
- Latency from the mov sample to moc = 1: write N cycles (word 4); read N+1 cycles (word 5).
- DONE:
  - moc = 1, registered.
  - Stays in DONE while mov = 1; returns to IDLE with moc = 0 on the first edge where mov = 0.
  - If mov drops during XFER, the transfer still completes and moc pulses for exactly one cycle.
- MAR bits above ADDR_WIDTH are ignored; they are not an error.
- ram_we is never high outside XFER.

Optional Feature:
- MEM_HANDSHAKE_SIGN_EXT_EN:
  - Defined: byte reads are sign-extended from bit 7 and halfword reads from bit 15 into the MDR.
  - Undefined: both are zero-extended.
  - Word accesses and all writes are identical in both builds.

Decomposition:
- Shared package mem_pkg holds:
  - the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD);
  - the state typedef (IDLE/XFER/DONE);
  - MEM_BYTES = 512 and the address width.
- One natural sub-module, mem_byte_pack: combinational byte select for writes and extension for reads, given size. The FSM and registers stay in the top module.
- The bench provides a 512x8 synchronous-read byte RAM model.

Test Plan:
1. Word write then read: MAR = 0x10, MDR = 0xDEADBEEF, rw = 0, mov → RAM[0x10..0x13] = DE AD BE EF, moc 4 cycles after the mov sample. Read back → mdr_out = 0xDEADBEEF, moc after 5 cycles.
2. Byte read 0x80 at address 0x21, with and without MEM_HANDSHAKE_SIGN_EXT_EN → 0xFFFFFF80 / 0x00000080. Halfword 0x8001 at 0x22 → 0xFFFF8001 / 0x00008001.
3. Misaligned word write at MAR = 0x06 → moc and align_err both 1 one cycle after mov, ram_we never asserted, RAM unchanged.
4. Address wrap: word write at MAR = 0x1FC and a byte write with MAR = 0x0000_0201 → bytes land at 0x1FC..0x1FF and at 0x001 respectively.
5. Handshake: mov held high 3 extra cycles → moc held for the same cycles, then drops one cycle after mov falls. mov dropped during XFER → one-cycle moc pulse. mar_ld during XFER → MAR unchanged.
6. Reset asserted asynchronously at the second byte of a word write → immediately moc = 0, ram_we = 0, MAR = MDR = 0, state IDLE. Only the first byte is written.
